// File: rtl/riscv_ex_pipeline.sv
// rtl/riscv_ex_pipeline.sv - EX stage skid buffer: in-order circular FIFO between ID and MEM/WB
//
// Ports:
//   clk          rising-edge clock
//   rstn         synchronous active-low reset
//   id_ex_rdy    upstream offers a payload
//   id_ex_ack    block accepts the upstream payload this cycle
//   id_ex_data   upstream payload (DATA_W bits)
//   mem_wb_rdy   block presents a payload downstream
//   mem_wb_ack   downstream takes the presented payload
//   mem_wb_data  downstream payload (DATA_W bits)
module riscv_ex_pipeline #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              id_ex_rdy,
  output logic              id_ex_ack,
  input  logic [DATA_W-1:0] id_ex_data,
  output logic              mem_wb_rdy,
  input  logic              mem_wb_ack,
  output logic [DATA_W-1:0] mem_wb_data
);

  // A depth-1 buffer still needs a one-bit pointer to keep the indexing legal.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;

  // Ack/rdy depend only on occupancy, never on the other side's handshake,
  // so a full buffer cannot pass a payload straight through in one cycle.
  assign id_ex_ack   = (count < FULL_CNT) && rstn;
  assign mem_wb_rdy  = (count != '0) && rstn;
  assign mem_wb_data = mem[rd_ptr];

  assign push = id_ex_rdy && id_ex_ack;
  assign pop  = mem_wb_rdy && mem_wb_ack;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= id_ex_data;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rstn && push && (count == FULL_CNT)) begin
      $display("ERROR: overflow");
    end
    if (rstn && pop && (count == '0)) begin
      $display("ERROR: underflow");
    end
  end
`endif

endmodule

// File: tb/tb_riscv_ex_pipeline.sv
// tb/tb_riscv_ex_pipeline.sv - directed vector table plus queue scoreboard for riscv_ex_pipeline
module tb_riscv_ex_pipeline;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;
  localparam int N_RAND = 1000;
  localparam int LIMIT  = 30000;

  logic              clk;
  logic              rstn;
  logic              id_ex_rdy;
  logic              id_ex_ack;
  logic [DATA_W-1:0] id_ex_data;
  logic              mem_wb_rdy;
  logic              mem_wb_ack;
  logic [DATA_W-1:0] mem_wb_data;

  riscv_ex_pipeline #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .id_ex_rdy  (id_ex_rdy),
    .id_ex_ack  (id_ex_ack),
    .id_ex_data (id_ex_data),
    .mem_wb_rdy (mem_wb_rdy),
    .mem_wb_ack (mem_wb_ack),
    .mem_wb_data(mem_wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              rstn;
    logic              rdy;
    logic [DATA_W-1:0] din;
    logic              ack;
    logic              e_ack;
    logic              e_rdy;
    logic              chk_data;
    logic [DATA_W-1:0] e_data;
  } vec_t;

  vec_t              vq[$];
  logic [DATA_W-1:0] sb[$];
  logic [DATA_W-1:0] src[$];
  int                n_checks = 0;
  int                n_fail   = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic rdy, input logic [DATA_W-1:0] din, input logic ack,
                     input logic e_ack, input logic e_rdy, input logic chk, input logic [DATA_W-1:0] e_data);
    vec_t v;
    v = '{r, rdy, din, ack, e_ack, e_rdy, chk, e_data};
    vq.push_back(v);
  endtask

  // One cycle against the queue model: outputs are predicted from the model's
  // occupancy, then the model applies the handshake it expects at the edge.
  task automatic sb_step(input logic rdy, input logic [DATA_W-1:0] d, input logic ack,
                         output logic pushed, output logic popped);
    logic e_ack;
    logic e_rdy;
    id_ex_rdy  = rdy;
    id_ex_data = d;
    mem_wb_ack = ack;
    e_ack = (sb.size() < DEPTH);
    e_rdy = (sb.size() > 0);
    @(negedge clk);
    check("sb_id_ex_ack", {31'b0, id_ex_ack}, {31'b0, e_ack});
    check("sb_mem_wb_rdy", {31'b0, mem_wb_rdy}, {31'b0, e_rdy});
    if (e_rdy) check("sb_mem_wb_data", mem_wb_data, sb[0]);
    popped = e_rdy && ack;
    pushed = rdy && e_ack;
    if (popped) void'(sb.pop_front());
    if (pushed) sb.push_back(d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic pu;
    logic po;
    int   sent;
    int   got;
    int   cyc;
    int   up_left;
    int   dn_left;
    logic up_on;
    logic dn_on;

    rstn       = 1'b0;
    id_ex_rdy  = 1'b0;
    id_ex_data = '0;
    mem_wb_ack = 1'b0;

    // rstn rdy din ack | e_ack e_rdy chk e_data
    add(0, 0, 32'h0,         0, 0, 0, 0, 32'h0);
    add(0, 1, 32'hDEAD_BEEF, 1, 0, 0, 0, 32'h0);
    add(1, 0, 32'h0,         0, 1, 0, 1, 32'h0);
    add(1, 1, 32'h1234_5678, 1, 1, 0, 1, 32'h0);
    add(1, 0, 32'h0,         1, 1, 1, 1, 32'h1234_5678);
    add(1, 0, 32'h0,         0, 1, 0, 0, 32'h0);
    add(1, 1, 32'hA,         0, 1, 0, 0, 32'h0);
    add(1, 1, 32'hB,         0, 1, 1, 1, 32'hA);
    add(1, 1, 32'hC,         0, 0, 1, 1, 32'hA);
    add(1, 1, 32'hC,         1, 0, 1, 1, 32'hA);
    add(1, 1, 32'hC,         1, 1, 1, 1, 32'hB);
    add(1, 0, 32'h0,         0, 1, 1, 1, 32'hC);
    add(1, 0, 32'h0,         0, 1, 1, 1, 32'hC);
    add(1, 0, 32'h0,         1, 1, 1, 1, 32'hC);
    add(1, 0, 32'h0,         0, 1, 0, 0, 32'h0);
    add(1, 1, 32'hD1D1_D1D1, 0, 1, 0, 0, 32'h0);
    add(1, 1, 32'hD2D2_D2D2, 0, 1, 1, 1, 32'hD1D1_D1D1);
    add(0, 0, 32'h0,         0, 0, 0, 0, 32'h0);
    add(1, 0, 32'h0,         1, 1, 0, 1, 32'h0);
    add(1, 0, 32'h0,         1, 1, 0, 1, 32'h0);

    @(posedge clk);
    #1;
    for (int i = 0; i < vq.size(); i++) begin
      rstn       = vq[i].rstn;
      id_ex_rdy  = vq[i].rdy;
      id_ex_data = vq[i].din;
      mem_wb_ack = vq[i].ack;
      @(negedge clk);
      check($sformatf("vec%0d_id_ex_ack", i), {31'b0, id_ex_ack}, {31'b0, vq[i].e_ack});
      check($sformatf("vec%0d_mem_wb_rdy", i), {31'b0, mem_wb_rdy}, {31'b0, vq[i].e_rdy});
      if (vq[i].chk_data) check($sformatf("vec%0d_mem_wb_data", i), mem_wb_data, vq[i].e_data);
      @(posedge clk);
      #1;
    end

    // Steady stream at occupancy 1: one in, one out every cycle.
    rstn = 1'b1;
    sb_step(1'b1, $urandom, 1'b0, pu, po);
    for (int i = 0; i < 10; i++) begin
      sb_step(1'b1, $urandom, 1'b1, pu, po);
      check("steady_push", {31'b0, pu}, 32'h1);
      check("steady_pop", {31'b0, po}, 32'h1);
    end
    cyc = 0;
    while (sb.size() > 0 && cyc < 10) begin
      sb_step(1'b0, '0, 1'b1, pu, po);
      cyc++;
    end
    check("steady_drained", sb.size(), 0);

    // Random stalls and bursts on both sides.
    for (int i = 0; i < N_RAND; i++) src.push_back($urandom);
    sent = 0; got = 0; cyc = 0;
    up_left = 0; dn_left = 0; up_on = 1'b0; dn_on = 1'b0;
    while (got < N_RAND && cyc < LIMIT) begin
      if (up_left == 0) begin
        up_on   = !up_on;
        up_left = up_on ? $urandom_range(1, 3) : $urandom_range(1, 5);
      end
      if (dn_left == 0) begin
        dn_on   = !dn_on;
        dn_left = dn_on ? $urandom_range(1, 3) : $urandom_range(1, 5);
      end
      up_left--;
      dn_left--;
      sb_step(up_on && (sent < N_RAND), (sent < N_RAND) ? src[sent] : DATA_W'($urandom), dn_on, pu, po);
      if (pu) sent++;
      if (po) got++;
      cyc++;
    end
    check("random_words_out", got, N_RAND);
    check("random_words_in", sent, N_RAND);

    id_ex_rdy  = 1'b0;
    mem_wb_ack = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_ex_pipeline.md
RISCV_EX_PIPELINE -- requirements
Module: riscv_ex_pipeline

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the width of the instruction/data payload.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving internal entry count; legal range 1..3.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port id_ex_rdy, input, 1 bit: upstream (ID) has a valid payload.
REQ-006 The block SHALL have port id_ex_ack, output, 1 bit: the block accepts the upstream payload this cycle.
REQ-007 The block SHALL have port id_ex_data, input, DATA_W bits: upstream payload.
REQ-008 The block SHALL have port mem_wb_rdy, output, 1 bit: the block presents a valid payload downstream (MEM/WB).
REQ-009 The block SHALL have port mem_wb_ack, input, 1 bit: downstream accepts the presented payload.
REQ-010 The block SHALL have port mem_wb_data, output, DATA_W bits: downstream payload.

Function
REQ-011 Push SHALL occur only on a rising edge where id_ex_rdy=1 and id_ex_ack=1; pop only where mem_wb_rdy=1 and mem_wb_ack=1.
REQ-012 Payloads SHALL pass through unmodified and in strict arrival order; none dropped, none duplicated.
REQ-013 Storage SHALL be a circular buffer of DEPTH entries with write pointer, read pointer (each wrapping DEPTH-1 -> 0) and occupancy count 0..DEPTH.
REQ-014 id_ex_ack SHALL equal (count < DEPTH) AND rstn; it is independent of id_ex_rdy and of mem_wb_ack (no same-cycle pass when full).
REQ-015 mem_wb_rdy SHALL equal (count > 0) AND rstn; it is independent of mem_wb_ack.
REQ-016 mem_wb_data SHALL equal the entry at the read pointer and stay stable while mem_wb_rdy=1 and no pop occurs.
REQ-017 No bypass: a payload pushed at edge N SHALL first be presented at mem_wb_data with mem_wb_rdy=1 after edge N (minimum latency 1 cycle).
REQ-018 Push only: count+1, write pointer advances. Pop only: count-1, read pointer advances. Simultaneous push and pop: count unchanged, both pointers advance.
REQ-019 When count=DEPTH, id_ex_ack SHALL be 0 even if mem_wb_ack=1 that cycle; ack returns to 1 the cycle after a pop.
REQ-020 When count=0, mem_wb_rdy SHALL be 0 and a push SHALL not be visible until the next cycle.
REQ-021 The block SHALL never hold more than 3 payloads, so a depth-3 in-order scoreboard on its ports never overflows.
REQ-022 The simulation-only check SHALL print "ERROR: overflow" on a push while full, and "ERROR: underflow" on a pop while empty; excluded from synthesis.
REQ-023 Upstream id_ex_rdy and downstream mem_wb_ack MAY toggle arbitrarily per cycle; behaviour SHALL depend only on the handshake at each edge.

Reset
REQ-024 On a rising edge with rstn=0: count=0, both pointers=0, all storage entries=0.
REQ-025 While rstn=0: id_ex_ack=0 and mem_wb_rdy=0 (combinationally); after release, id_ex_ack=1, mem_wb_rdy=0, mem_wb_data=0.
REQ-026 Reset asserted mid-operation SHALL discard all held payloads; no payload accepted before reset is emitted afterwards.

Verification
REQ-027 After reset, push 0x1234_5678 with mem_wb_ack=1 -> next cycle mem_wb_rdy=1, mem_wb_data=0x1234_5678; popped; mem_wb_rdy=0 the cycle after.
REQ-028 mem_wb_ack=0, push 0xA, 0xB (DEPTH=2) -> id_ex_ack=0 with count=2; raise mem_wb_ack -> outputs 0xA then 0xB; id_ex_ack=1 the cycle after first pop.
REQ-029 Full plus mem_wb_ack=1 plus id_ex_rdy=1 in the same cycle -> only pop occurs; new payload accepted the next cycle.
REQ-030 Steady id_ex_rdy=1, mem_wb_ack=1, count=1 -> one push and one pop each cycle, throughput 1/cycle, order preserved over 10 random words.
REQ-031 Random 1-5 cycle stalls / 1-3 cycle bursts on both sides, 1000 random words -> output sequence equals input sequence, zero ERROR messages.
REQ-032 Assert rstn=0 for 1 cycle with 2 entries held -> mem_wb_rdy=0, id_ex_ack=1 after release; held data never appears.
